// File: rtl/sig_gen_param.sv
// Multi-waveform generator (square, sawtooth, triangle, hold) with a programmable
// prescaler, step and duty. Mode switches continue from the current level.
module sig_gen_param #(
  parameter int DATA_WIDTH = 5,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            wave_sel,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] duty,
  input  logic [DIV_WIDTH-1:0]  div,
  output logic [DATA_WIDTH-1:0] wave,
  output logic                  wave_valid,
  output logic                  period_start
);

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic [DATA_WIDTH-1:0] AMP_MAX  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] AMP_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] AMP_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]  CNT_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0]  CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0]  cnt_r;
  logic [DATA_WIDTH-1:0] wave_r;
  logic [DATA_WIDTH-1:0] phase_r;
  logic                  dir_r;       // 1 = descending
  logic [1:0]            prev_sel_r;  // mode applied on the last tick
  logic                  wave_valid_r;
  logic                  period_start_r;

  logic                  tick_s;
  logic [DATA_WIDTH-1:0] s_s;
  logic [DATA_WIDTH:0]   acc_sum_s;
  logic [DATA_WIDTH:0]   tri_sum_s;
  logic                  dir_eff_s;
  logic [DATA_WIDTH-1:0] wave_n_s;
  logic [DATA_WIDTH-1:0] phase_n_s;
  logic                  dir_n_s;
  logic                  ps_n_s;

  assign tick_s    = enable && (cnt_r >= div);
  assign s_s       = (step == AMP_ZERO) ? AMP_ONE : step;
  assign acc_sum_s = {1'b0, phase_r} + {1'b0, s_s};
  assign tri_sum_s = {1'b0, wave_r} + {1'b0, s_s};
  // Entering triangle re-derives direction from the level we are at.
  assign dir_eff_s = (prev_sel_r != MODE_TRI) ? (wave_r == AMP_MAX) : dir_r;

  // Next waveform state for the mode currently selected.
  always_comb begin
    wave_n_s  = wave_r;
    phase_n_s = phase_r;
    dir_n_s   = dir_r;
    ps_n_s    = 1'b0;
    case (wave_sel)
      MODE_SQUARE: begin
        phase_n_s = acc_sum_s[DATA_WIDTH-1:0];
        wave_n_s  = (acc_sum_s[DATA_WIDTH-1:0] < duty) ? AMP_MAX : AMP_ZERO;
        ps_n_s    = acc_sum_s[DATA_WIDTH];
      end
      MODE_SAW: begin
        phase_n_s = acc_sum_s[DATA_WIDTH-1:0];
        wave_n_s  = acc_sum_s[DATA_WIDTH-1:0];
        ps_n_s    = acc_sum_s[DATA_WIDTH];
      end
      MODE_TRI: begin
        if (!dir_eff_s) begin
          if (tri_sum_s >= {1'b0, AMP_MAX}) begin
            wave_n_s = AMP_MAX;
            dir_n_s  = 1'b1;
          end else begin
            wave_n_s = tri_sum_s[DATA_WIDTH-1:0];
            dir_n_s  = 1'b0;
          end
        end else begin
          if (wave_r <= s_s) begin
            wave_n_s = AMP_ZERO;
            dir_n_s  = 1'b0;
            ps_n_s   = 1'b1;
          end else begin
            wave_n_s = wave_r - s_s;
            dir_n_s  = 1'b1;
          end
        end
        phase_n_s = wave_n_s;
      end
      MODE_HOLD: begin
        ps_n_s = 1'b0;
      end
      default: begin
        ps_n_s = 1'b0;
      end
    endcase
  end

  // Prescaler, waveform state and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r          <= CNT_ZERO;
      wave_r         <= AMP_ZERO;
      phase_r        <= AMP_ZERO;
      dir_r          <= 1'b0;
      prev_sel_r     <= MODE_SQUARE;
      wave_valid_r   <= 1'b0;
      period_start_r <= 1'b0;
    end else begin
      wave_valid_r   <= tick_s;
      period_start_r <= tick_s & ps_n_s;
      if (enable) begin
        cnt_r <= tick_s ? CNT_ZERO : (cnt_r + CNT_ONE);
      end
      if (tick_s) begin
        wave_r     <= wave_n_s;
        phase_r    <= phase_n_s;
        dir_r      <= dir_n_s;
        prev_sel_r <= wave_sel;
      end
    end
  end

  assign wave         = wave_r;
  assign wave_valid   = wave_valid_r;
  assign period_start = period_start_r;

endmodule

// File: tb/tb_sig_gen_param.sv
// Table-driven bench for sig_gen_param (DATA_WIDTH=5, DIV_WIDTH=8) with
// hand-computed per-cycle expectations and a few hand-written sequences.
module tb_sig_gen_param;

  localparam logic [1:0] SQ  = 2'd0;
  localparam logic [1:0] SAW = 2'd1;
  localparam logic [1:0] TRI = 2'd2;
  localparam logic [1:0] HLD = 2'd3;

  typedef struct {
    logic       r;
    logic       en;
    logic [1:0] sel;
    logic [4:0] st;
    logic [4:0] du;
    logic [7:0] dv;
    logic [4:0] w;
    logic       v;
    logic       p;
  } vec_t;

  vec_t vecs[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] wave_sel = 2'd0;
  logic [4:0] step = 5'd0;
  logic [4:0] duty = 5'd0;
  logic [7:0] div = 8'd0;
  logic [4:0] wave;
  logic       wave_valid;
  logic       period_start;

  int errors = 0;
  int checks = 0;

  sig_gen_param #(.DATA_WIDTH(5), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wave_sel(wave_sel), .step(step),
    .duty(duty), .div(div), .wave(wave), .wave_valid(wave_valid),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic en, input logic [1:0] sel,
                     input logic [4:0] st, input logic [4:0] du, input logic [7:0] dv,
                     input logic [4:0] w, input logic v, input logic p);
    vec_t x;
    x.r = r; x.en = en; x.sel = sel; x.st = st; x.du = du; x.dv = dv;
    x.w = w; x.v = v; x.p = p;
    vecs.push_back(x);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int w, input int v, input int p);
    check({nm, " wave"}, int'(wave), w);
    check({nm, " valid"}, int'(wave_valid), v);
    check({nm, " pstart"}, int'(period_start), p);
  endtask

  task automatic rst_vec();
    add(1'b1, 1'b1, SQ, 5'd1, 5'd0, 8'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset (enable high, reset must win), then sawtooth step 1, div 0.
    rst_vec();
    for (int k = 1; k <= 33; k++)
      add(1'b0, 1'b1, SAW, 5'd1, 5'd0, 8'd0, 5'(k % 32), 1'b1, k == 32);

    // Square duty 16 for two periods, then duty 0.
    rst_vec();
    for (int k = 1; k <= 64; k++)
      add(1'b0, 1'b1, SQ, 5'd1, 5'd16, 8'd0, ((k % 32) < 16) ? 5'd31 : 5'd0, 1'b1, (k % 32) == 0);
    for (int k = 1; k <= 8; k++)
      add(1'b0, 1'b1, SQ, 5'd1, 5'd0, 8'd0, 5'd0, 1'b1, 1'b0);

    // Triangle step 4 from reset.
    rst_vec();
    for (int k = 1; k <= 7; k++)
      add(1'b0, 1'b1, TRI, 5'd4, 5'd0, 8'd0, 5'(4 * k), 1'b1, 1'b0);
    add(1'b0, 1'b1, TRI, 5'd4, 5'd0, 8'd0, 5'd31, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      add(1'b0, 1'b1, TRI, 5'd4, 5'd0, 8'd0, 5'(27 - 4 * k), 1'b1, 1'b0);
    add(1'b0, 1'b1, TRI, 5'd4, 5'd0, 8'd0, 5'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, TRI, 5'd4, 5'd0, 8'd0, 5'd4, 1'b1, 1'b0);

    // Triangle step 0 behaves as step 1: 0..31..0.
    rst_vec();
    for (int k = 1; k <= 31; k++)
      add(1'b0, 1'b1, TRI, 5'd0, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++)
      add(1'b0, 1'b1, TRI, 5'd0, 5'd0, 8'd0, 5'(31 - k), 1'b1, 1'b0);
    add(1'b0, 1'b1, TRI, 5'd0, 5'd0, 8'd0, 5'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, TRI, 5'd0, 5'd0, 8'd0, 5'd1, 1'b1, 1'b0);

    // div 3: tick every 4th cycle; enable low holds count and level.
    rst_vec();
    for (int k = 1; k <= 14; k++)
      add(1'b0, 1'b1, SAW, 5'd1, 5'd0, 8'd3, 5'(k / 4), (k % 4) == 0, 1'b0);
    for (int k = 0; k < 10; k++)
      add(1'b0, 1'b0, SAW, 5'd1, 5'd0, 8'd3, 5'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, SAW, 5'd1, 5'd0, 8'd3, 5'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, SAW, 5'd1, 5'd0, 8'd3, 5'd4, 1'b1, 1'b0);

    // Mode switches: saw->tri at 10, tri descending at 20 -> saw,
    // saw at 31 -> tri, hold 5 ticks, hold -> tri.
    rst_vec();
    for (int k = 1; k <= 10; k++)
      add(1'b0, 1'b1, SAW, 5'd1, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);
    for (int k = 11; k <= 31; k++)
      add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);
    for (int k = 30; k >= 20; k--)
      add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);
    for (int k = 21; k <= 31; k++)
      add(1'b0, 1'b1, SAW, 5'd1, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);
    add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'd30, 1'b1, 1'b0);
    add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'd29, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 1'b1, HLD, 5'd1, 5'd0, 8'd0, 5'd29, 1'b1, 1'b0);
    add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'd30, 1'b1, 1'b0);

    // Reset mid-descent at 17, then climb again from 0.
    rst_vec();
    for (int k = 1; k <= 31; k++)
      add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);
    for (int k = 30; k >= 17; k--)
      add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);
    add(1'b1, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++)
      add(1'b0, 1'b1, TRI, 5'd1, 5'd0, 8'd0, 5'(k), 1'b1, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; enable = vecs[i].en; wave_sel = vecs[i].sel;
      step = vecs[i].st; duty = vecs[i].du; div = vecs[i].dv;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), int'(vecs[i].w), int'(vecs[i].v), int'(vecs[i].p));
    end

    // Hand sequence: a reduced div takes effect on the very next edge.
    rst = 1'b1; enable = 1'b1; wave_sel = SAW; step = 5'd1; div = 8'd7;
    @(posedge clk); #1;
    check_all("div_rst", 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_all("div_wait", 0, 0, 0);
    end
    div = 8'd1;
    @(posedge clk); #1;
    check_all("div_cut", 1, 1, 0);
    @(posedge clk); #1;
    check_all("div_cnt0", 1, 0, 0);
    @(posedge clk); #1;
    check_all("div_tick2", 2, 1, 0);

    // Hand sequence: square duty=MAX is high except where phase lands on MAX.
    rst = 1'b1; wave_sel = SQ; duty = 5'd31; div = 8'd0; step = 5'd15;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("dmax_p15", 31, 1, 0);
    step = 5'd16;
    @(posedge clk); #1;
    check_all("dmax_p31", 0, 1, 0);
    step = 5'd1;
    @(posedge clk); #1;
    check_all("dmax_wrap", 31, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sig_gen_param.md
Name: sig_gen_param

Overview:
- Parametrised multi-waveform generator: square (programmable duty), sawtooth, triangle and hold.
- Amplitude width, frequency prescale and step are all programmable.
- Mode switches are phase-continuous: no jump to zero.
- Feeds DAC/test-pattern paths. Single clock domain, registered outputs.

Parameters:
- DATA_WIDTH, 5, amplitude bits. MAX = 2^DATA_WIDTH-1.
- DIV_WIDTH, 8, prescaler divisor width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  run. Low freezes the generator.
- wave_sel  input  2  0 = square, 1 = sawtooth, 2 = triangle, 3 = hold.
- step  input  DATA_WIDTH  amplitude increment per tick. 0 is treated as 1.
- duty  input  DATA_WIDTH  square threshold. Output is high while phase < duty.
- div  input  DIV_WIDTH  tick every div+1 enabled cycles.
- wave  output  DATA_WIDTH  waveform sample (registered).
- wave_valid  output  1  one-cycle pulse on the edge where wave updates.
- period_start  output  1  one-cycle pulse, coincident with wave_valid, at each period start.

Behaviour:
- Reset: one clk edge with rst = 1 sets wave = 0, phase = 0, dir = up, prescaler = 0, wave_valid = 0, period_start = 0. Reset overrides enable and is honoured mid-operation.
- Prescaler:
  - When enable = 1: if cnt >= div, then tick = 1 and cnt <= 0; otherwise cnt <= cnt+1.
  - When enable = 0: cnt is held, tick = 0, all state is held, wave_valid = 0.
  - A reduced div takes effect immediately.
- Inputs (wave_sel, step, duty) are sampled only on tick cycles. State, wave and the pulses all update on the tick edge, with zero extra latency.
- Let s = (step == 0) ? 1 : step. phase is a DATA_WIDTH-bit accumulator.
- Sawtooth:
  - phase_n = (phase + s) mod 2^DATA_WIDTH; wave <= phase_n.
  - period_start = 1 when the addition wraps (carry out).
- Square:
  - phase_n as in sawtooth; wave <= (phase_n < duty) ? MAX : 0.
  - period_start on carry out.
  - duty = 0 gives constant 0; duty = MAX gives MAX except at phase MAX.
- Triangle (dir register; arithmetic in DATA_WIDTH+1 bits, no overflow):
  - Up: if wave + s >= MAX, then wave <= MAX and dir <= down; else wave <= wave + s.
  - Down: if wave <= s, then wave <= 0, dir <= up, period_start = 1; else wave <= wave - s.
  - phase <= new wave every tick, so a later switch to sawtooth or square continues from the current level.
- Hold (3): wave, phase and dir are frozen. wave_valid still pulses on tick; period_start = 0.
- Mode switch takes effect on the first tick with the new wave_sel:
  - Into triangle from another mode: start from the current wave; dir <= down if wave == MAX, else up. Then apply the triangle rule on that same tick.
  - Into sawtooth/square: phase continues from its current value. No reset of wave.
- Simultaneous tick and mode change: the new mode's rule is applied to the current state on that tick.

Test Plan:
1. DATA_WIDTH=5, div=0, step=1, sawtooth, after reset:
   - Required: wave 1, 2, ..., 31, 0, 1 on consecutive cycles.
   - wave_valid stays high every cycle.
   - period_start is high exactly on the 31→0 edge.
2. Square, duty=16, step=1, div=0:
   - Required: steady state of 16 cycles at 31 (phase 0..15) and 16 cycles at 0 (phase 16..31).
   - period_start on the phase-0 edge.
   - duty=0 gives constant 0.
3. Triangle, step=4, div=0, from reset:
   - Required: wave 4, 8, ..., 28, 31, 27, 23, 19, 15, 11, 7, 3, 0, 4.
   - period_start on the edge where wave becomes 0.
   - step=0 gives ±1 steps: 0..31..0.
4. div=3, sawtooth, step=1:
   - Required: wave_valid on every 4th cycle, with wave incrementing only on those cycles.
   - enable low for 10 cycles: wave and cnt hold. On re-enable, the next tick occurs after the remaining count.
5. Mode switches:
   - Sawtooth at wave=10, switch to triangle → 11, 12, ...
   - Triangle descending at 20 (step=1), switch to sawtooth → 21, 22, ...
   - Switch into triangle at wave=31 → 30.
   - Hold for 5 ticks: wave constant, wave_valid pulses.
6. rst=1 for one cycle during triangle descent at wave=17:
   - Required: next edge gives wave=0 and outputs 0.
   - After release with step=1: 1, 2, 3 ... (dir up).
